// File: rtl/pcie_pio_if.sv
// pcie_pio_if: 32-bit TRN-style stream between the PCIe endpoint core and the
// PIO target. Holds the rx (core -> target) and tx (target -> core) channels.
//
// Handshake: on either channel, a DWORD transfers on the rising clock edge
// where valid && ready are both 1. Once the sender asserts valid, it holds
// data, sof and eof stable until that edge. The receiver may change ready at
// any time.
interface pcie_pio_if;
  logic [31:0] rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_sof;
  logic        tx_eof;
  logic        tx_valid;
  logic        tx_ready;

  // Endpoint-core side: sends requests and receives completions.
  modport master (
    output rx_data, rx_sof, rx_eof, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_sof, tx_eof, tx_valid
  );

  // PIO target side.
  modport slave (
    input  rx_data, rx_sof, rx_eof, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_sof, tx_eof, tx_valid
  );
endinterface

// File: rtl/pcie_pio_target.sv
// pcie_pio_target: PIO target behind the ml605 PCIe endpoint.
//
// The target accepts 3DW MWr32 and MRd32 TLPs whose length is 1 DW. These
// TLPs access an internal DWORD memory. For every accepted read, the target
// returns a 4-DWORD CplD. All other TLPs are consumed and dropped.
//
// Optional macro PIO_ID_REG_EN: when defined, DWORD address 0 becomes a
// read-only ID register that returns {DEVICE_ID, VENDOR_ID}.
module pcie_pio_target #(
  parameter int          MEM_AW    = 8,
  parameter logic [15:0] DEVICE_ID = 16'h6011,
  parameter logic [15:0] VENDOR_ID = 16'h10EE
) (
  input  logic         sys_clk,
  input  logic         sys_reset_n,
  pcie_pio_if.slave    bus,
  input  logic [15:0]  cfg_completer_id,
  output logic [2:0]   fsm_state
);

`ifdef PIO_ID_REG_EN
  localparam logic ID_REG_EN = 1'b1;
`else
  localparam logic ID_REG_EN = 1'b0;
`endif
  localparam logic [31:0] ID_WORD = {DEVICE_ID, VENDOR_ID};

  typedef enum logic [2:0] {
    RX_DW0  = 3'd0,
    RX_DW1  = 3'd1,
    RX_DW2  = 3'd2,
    RX_DATA = 3'd3,
    RX_DROP = 3'd4,
    RD_WAIT = 3'd5,
    TX_CPL  = 3'd6
  } state_t;

  state_t state, state_n;

  logic              rx_ready_q;
  logic              rx_acc;
  logic              hdr_ok;
  logic              decode_dw0;
  logic              wr_en;
  logic              addr_is_id;
  logic              rd_phase;
  logic [1:0]        beat;

  // Values captured from the request header.
  logic              is_wr;
  logic [2:0]        tc;
  logic [1:0]        attr;
  logic [15:0]       req_id;
  logic [7:0]        tag;
  logic [3:0]        first_be;
  logic [MEM_AW-1:0] addr;
  logic [4:0]        addr_lo;
  logic [31:0]       rd_data;

  logic [31:0]       mem [2**MEM_AW];

  assign rx_acc     = bus.rx_valid && rx_ready_q;
  assign hdr_ok     = (bus.rx_data[31:24] == 8'h40 || bus.rx_data[31:24] == 8'h00) &&
                      (bus.rx_data[9:0] == 10'd1);
  // A sof beat starts a new header, even in the middle of a TLP that is still
  // being decoded.
  assign decode_dw0 = rx_acc && bus.rx_sof &&
                      (state == RX_DW0 || state == RX_DW1 ||
                       state == RX_DW2 || state == RX_DATA);
  assign addr_is_id = ID_REG_EN && (addr == '0);
  assign fsm_state  = state;
  assign bus.rx_ready = rx_ready_q;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) state <= RX_DW0;
    else              state <= state_n;
  end

  // Next-state decode and write strobe.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    if (decode_dw0) begin
      if (hdr_ok && !bus.rx_eof) state_n = RX_DW1;
      else if (bus.rx_eof)       state_n = RX_DW0;
      else                       state_n = RX_DROP;
    end else begin
      case (state)
        RX_DW0:  state_n = RX_DW0;
        RX_DW1:  if (rx_acc) state_n = bus.rx_eof ? RX_DW0 : RX_DW2;
        RX_DW2: begin
          if (rx_acc) begin
            if (bus.rx_eof) state_n = is_wr ? RX_DW0 : RD_WAIT;
            else             state_n = is_wr ? RX_DATA : RX_DROP;
          end
        end
        RX_DATA: begin
          if (rx_acc) begin
            wr_en   = 1'b1;
            state_n = bus.rx_eof ? RX_DW0 : RX_DROP;
          end
        end
        RX_DROP: if (rx_acc && bus.rx_eof) state_n = RX_DW0;
        RD_WAIT: if (rd_phase) state_n = TX_CPL;
        TX_CPL:  if (bus.tx_ready && beat == 2'd3) state_n = RX_DW0;
        default: state_n = RX_DW0;
      endcase
    end
  end

  // rx_ready is low for the whole read and completion phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) rx_ready_q <= 1'b0;
    else              rx_ready_q <= (state_n != RD_WAIT) && (state_n != TX_CPL);
  end

  // RAM read-latency phase and completion beat counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      rd_phase <= 1'b0;
      beat     <= 2'd0;
    end else begin
      rd_phase <= (state == RD_WAIT);
      if (state != TX_CPL) beat <= 2'd0;
      else if (bus.tx_ready) beat <= beat + 2'd1;
    end
  end

  // Header field capture. These registers need no reset.
  always_ff @(posedge sys_clk) begin
    if (decode_dw0) begin
      is_wr <= bus.rx_data[30];
      tc    <= bus.rx_data[22:20];
      attr  <= bus.rx_data[13:12];
    end else if (rx_acc && state == RX_DW1) begin
      req_id   <= bus.rx_data[31:16];
      tag      <= bus.rx_data[15:8];
      first_be <= bus.rx_data[3:0];
    end else if (rx_acc && state == RX_DW2) begin
      addr    <= bus.rx_data[MEM_AW+1:2];
      addr_lo <= bus.rx_data[6:2];
    end
  end

  // Byte-enabled DWORD memory. Contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en && !addr_is_id) begin
      for (int i = 0; i < 4; i++) begin
        if (first_be[i]) mem[addr][8*i +: 8] <= bus.rx_data[8*i +: 8];
      end
    end
  end

  // Synchronous read, performed in the first RD_WAIT cycle.
  always_ff @(posedge sys_clk) begin
    if (state == RD_WAIT && !rd_phase) rd_data <= addr_is_id ? ID_WORD : mem[addr];
  end

  // Completion output mux. It stays stable while tx_ready is low.
  always_comb begin
    bus.tx_valid = (state == TX_CPL);
    bus.tx_sof   = bus.tx_valid && (beat == 2'd0);
    bus.tx_eof   = bus.tx_valid && (beat == 2'd3);
    bus.tx_data  = 32'h0;
    if (bus.tx_valid) begin
      case (beat)
        2'd0: bus.tx_data = {1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'b0, 1'b0, 1'b0,
                             attr, 2'b00, 10'd1};
        2'd1: bus.tx_data = {cfg_completer_id, 3'b000, 1'b0, 12'd4};
        2'd2: bus.tx_data = {req_id, tag, 1'b0, addr_lo, 2'b00};
        default: bus.tx_data = rd_data;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_pio_target.sv
// tb_pcie_pio_target: directed bench for pcie_pio_target.
// It covers write/read round trips, byte enables, tx back-pressure, dropped
// and aborted TLPs, reset during a completion, and the address-0 behaviour.
module tb_pcie_pio_target;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic [15:0] cfg_completer_id;
  logic [2:0]  fsm_state;
  int          checks = 0;
  int          errors = 0;

  pcie_pio_if bus();

  pcie_pio_target dut (
    .sys_clk          (sys_clk),
    .sys_reset_n      (sys_reset_n),
    .bus              (bus),
    .cfg_completer_id (cfg_completer_id),
    .fsm_state        (fsm_state)
  );

  // Clock and reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Driver tasks. Each one starts and ends on a falling edge.
  task automatic send_beat(input logic [31:0] d, input logic sof, input logic eof);
    bit done;
    done = 0;
    bus.rx_data  = d;
    bus.rx_sof   = sof;
    bus.rx_eof   = eof;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.rx_ready === 1'b1) begin
        @(posedge sys_clk);
        done = 1;
      end else begin
        @(negedge sys_clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rx_accept: beat %h not accepted within 50 cycles (rx_ready=%b)", d, bus.rx_ready);
    end
    @(negedge sys_clk);
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
  endtask

  task automatic mwr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    send_beat(32'h4000_0001, 1'b1, 1'b0);
    send_beat({16'h0100, 8'h00, 4'h0, be}, 1'b0, 1'b0);
    send_beat(a, 1'b0, 1'b0);
    send_beat(d, 1'b0, 1'b1);
  endtask

  task automatic mrd(input logic [31:0] a, input logic [7:0] tg, input logic [15:0] rq);
    send_beat(32'h0000_0001, 1'b1, 1'b0);
    send_beat({rq, tg, 8'h0F}, 1'b0, 1'b0);
    send_beat(a, 1'b0, 1'b1);
  endtask

  // Gathers one completion with tx_ready held at 1 and records whether the
  // sof/eof framing was right. A timeout counts as a failed comparison.
  task automatic collect_cpl(output logic [31:0] c0, output logic [31:0] c1,
                             output logic [31:0] c2, output logic [31:0] c3,
                             output bit framing_ok);
    logic [31:0] w [4];
    bit seen;
    seen = 0;
    framing_ok = 1;
    for (int i = 0; i < 4; i++) w[i] = 32'hX;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.tx_valid === 1'b1) seen = 1;
      else @(negedge sys_clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      framing_ok = 0;
      $display("FAIL cpl_timeout: tx_valid=%b, required 1 within 20 cycles", bus.tx_valid);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.tx_valid !== 1'b1 || bus.tx_sof !== (i == 0) || bus.tx_eof !== (i == 3))
          framing_ok = 0;
        w[i] = bus.tx_data;
        @(negedge sys_clk);
      end
    end
    c0 = w[0]; c1 = w[1]; c2 = w[2]; c3 = w[3];
  endtask

  // Scenario tasks
  task automatic test_reset();
    sys_reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_sof !== 1'b0 ||
        bus.tx_eof !== 1'b0 || bus.tx_data !== 32'h0 || fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: rx_ready=%b tx_valid=%b sof=%b eof=%b data=%h state=%0d, required 0 0 0 0 0 0",
               bus.rx_ready, bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.tx_data, fsm_state);
    end
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rx_ready=%b, required 1", bus.rx_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] c0, c1, c2, c3;
    bit fr;
    mwr(32'h40, 4'hF, 32'hDEAD_BEEF);
    mrd(32'h40, 8'h05, 16'h0100);
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait_1: tx_valid=%b rx_ready=%b, required 0 0", bus.tx_valid, bus.rx_ready);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait_2: tx_valid=%b, required 0", bus.tx_valid);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_sof !== 1'b1 || bus.tx_data !== 32'h4A00_0001) begin
      errors++;
      $display("FAIL cpl_latency: tx_valid=%b sof=%b data=%h, required 1 1 4a000001",
               bus.tx_valid, bus.tx_sof, bus.tx_data);
    end
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c0 !== 32'h4A00_0001 || c1 !== 32'h0200_0004 || c2 !== 32'h0100_0540 ||
        c3 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_write_read: framing=%0d cpl=%h %h %h %h, required 1 4a000001 02000004 01000540 deadbeef",
               fr, c0, c1, c2, c3);
    end
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_cpl_ready: rx_ready=%b tx_valid=%b, required 1 0", bus.rx_ready, bus.tx_valid);
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] c0, c1, c2, c3;
    bit fr;
    mwr(32'h40, 4'b0011, 32'h1122_3344);
    mrd(32'h40, 8'h06, 16'h0100);
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c3 !== 32'hDEAD_3344 || c2 !== 32'h0100_0640) begin
      errors++;
      $display("FAIL partial_be: framing=%0d c2=%h c3=%h, required 1 01000640 dead3344", fr, c2, c3);
    end
    mwr(32'h40, 4'b0000, 32'hFFFF_FFFF);
    mrd(32'h40, 8'h06, 16'h0100);
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c3 !== 32'hDEAD_3344) begin
      errors++;
      $display("FAIL zero_be: framing=%0d c3=%h, required 1 dead3344", fr, c3);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] c0, c1, c2, c3;
    logic [31:0] snap_data;
    logic        snap_sof, snap_eof;
    bit fr, seen, stable;
    bus.tx_ready = 1'b0;
    mrd(32'h40, 8'h07, 16'h0100);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.tx_valid === 1'b1) seen = 1;
      else @(negedge sys_clk);
    end
    snap_data = bus.tx_data;
    snap_sof  = bus.tx_sof;
    snap_eof  = bus.tx_eof;
    stable = seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== snap_data || bus.tx_sof !== snap_sof ||
          bus.tx_eof !== snap_eof || bus.rx_ready !== 1'b0)
        stable = 0;
    end
    checks++;
    if (!stable || snap_data !== 32'h4A00_0001 || snap_sof !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: stable=%0d data=%h sof=%b rx_ready=%b, required 1 4a000001 1 0",
               stable, bus.tx_data, bus.tx_sof, bus.rx_ready);
    end
    bus.tx_ready = 1'b1;
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c0 !== 32'h4A00_0001 || c1 !== 32'h0200_0004 || c2 !== 32'h0100_0740 ||
        c3 !== 32'hDEAD_3344) begin
      errors++;
      $display("FAIL stall_release: framing=%0d cpl=%h %h %h %h, required 1 4a000001 02000004 01000740 dead3344",
               fr, c0, c1, c2, c3);
    end
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_rx_ready: rx_ready=%b, required 1", bus.rx_ready);
    end
  endtask

  task automatic test_drop();
    logic [31:0] c0, c1, c2, c3;
    bit fr, any_tx;
    // MRd with length 2
    send_beat(32'h0000_0002, 1'b1, 1'b0);
    send_beat(32'h0100_0A0F, 1'b0, 1'b0);
    send_beat(32'h0000_0040, 1'b0, 1'b1);
    // 4DW header
    send_beat(32'h2000_0001, 1'b1, 1'b0);
    send_beat(32'h0100_0B0F, 1'b0, 1'b0);
    send_beat(32'h0000_0000, 1'b0, 1'b0);
    send_beat(32'h0000_0040, 1'b0, 1'b1);
    // MRd cut short by eof on DW1
    send_beat(32'h0000_0001, 1'b1, 1'b0);
    send_beat(32'h0100_0C0F, 1'b0, 1'b1);
    // MWr cut short by eof on DW2
    send_beat(32'h4000_0001, 1'b1, 1'b0);
    send_beat(32'h0100_000F, 1'b0, 1'b0);
    send_beat(32'h0000_0040, 1'b0, 1'b1);
    any_tx = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.tx_valid !== 1'b0) any_tx = 1;
      @(negedge sys_clk);
    end
    checks++;
    if (any_tx || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_no_cpl: saw_tx_valid=%0d rx_ready=%b, required 0 1", any_tx, bus.rx_ready);
    end
    // MWr header abandoned by a new sof that starts an MRd
    send_beat(32'h4000_0001, 1'b1, 1'b0);
    send_beat(32'h0100_000F, 1'b0, 1'b0);
    mrd(32'h40, 8'h09, 16'h0100);
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c2 !== 32'h0100_0940 || c3 !== 32'hDEAD_3344) begin
      errors++;
      $display("FAIL restart_read: framing=%0d c2=%h c3=%h, required 1 01000940 dead3344", fr, c2, c3);
    end
  endtask

  task automatic test_reset_mid_cpl();
    logic [31:0] c0, c1, c2, c3;
    bit fr, seen;
    mrd(32'h40, 8'h0A, 16'h0100);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.tx_valid === 1'b1) seen = 1;
      else @(negedge sys_clk);
    end
    @(negedge sys_clk);
    checks++;
    if (!seen || bus.tx_data !== 32'h0200_0004 || bus.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_c1: seen=%0d tx_valid=%b data=%h, required 1 1 02000004", seen, bus.tx_valid, bus.tx_data);
    end
    sys_reset_n = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b0 || bus.tx_data !== 32'h0 || bus.tx_sof !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx_valid=%b rx_ready=%b data=%h sof=%b, required 0 0 0 0",
               bus.tx_valid, bus.rx_ready, bus.tx_data, bus.tx_sof);
    end
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    mrd(32'h40, 8'h0B, 16'h0100);
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c3 !== 32'hDEAD_3344) begin
      errors++;
      $display("FAIL mem_after_reset: framing=%0d c3=%h, required 1 dead3344", fr, c3);
    end
  endtask

  task automatic test_id_reg();
    logic [31:0] c0, c1, c2, c3;
    logic [31:0] exp_id;
    bit fr;
`ifdef PIO_ID_REG_EN
    exp_id = 32'h6011_10EE;
`else
    exp_id = 32'h0000_0000;
`endif
    mwr(32'h0, 4'hF, 32'h0);
    mrd(32'h0, 8'h11, 16'h0100);
    collect_cpl(c0, c1, c2, c3, fr);
    checks++;
    if (!fr || c2 !== 32'h0100_1100 || c3 !== exp_id) begin
      errors++;
      $display("FAIL addr0_read: framing=%0d c2=%h c3=%h, required 1 01001100 %h", fr, c2, c3, exp_id);
    end
  endtask

  // Sequence and final report
  initial begin
    bus.rx_data  = 32'h0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    cfg_completer_id = 16'h0200;
    @(negedge sys_clk);
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_pressure();
    test_drop();
    test_reset_mid_cpl();
    test_id_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
